// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage definitions.
// Holds the fetch FSM state encoding and the default address/instruction
// widths, reset PC and sequential PC increment. The condUnit and the decode
// stage import the same width constants so the buses line up.
package cpu_fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 32;
  localparam int unsigned FETCH_INSTR_W  = 32;
  localparam int unsigned FETCH_RESET_PC = 0;
  localparam int unsigned FETCH_PC_STEP  = 4;

  typedef enum logic [1:0] {
    S_START = 2'd0,  // first cycle after reset release
    S_REQ   = 2'd1,  // request outstanding at imemAddr
    S_BUF   = 2'd2,  // returned word parked in the skid buffer
    S_DROP  = 2'd3   // redirect taken, waiting to discard the old return
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding {instr, pc, valid}.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load              capture in_instr/in_pc and mark valid
//   unload            entry consumed, mark empty
//   clear             squash entry (redirect), wins over load and unload
//   in_instr, in_pc   word and address to capture
//   instr, pc, valid  stored entry
module fetch_skid_buf #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single outstanding instruction-memory request,
// IF/ID pipeline register, redirect on taken branch, one-entry skid buffer.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   stall                 hold IF/ID and PC
//   jmpR, jmpTarget       taken branch and its target (low 2 bits ignored)
//   imemReq, imemAddr     registered request, address stable until imemRdy
//   imemRdy, imemData     return handshake and fetched word
//   ifidValid/Instr/Pc    IF/ID register
//   dbg_state             current FSM state
// Handshake: a request is outstanding while imemReq=1; it completes in the
// cycle imemRdy=1, and imemAddr never changes while a request is outstanding.
module fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned RESET_PC = FETCH_RESET_PC,
  parameter int unsigned PC_STEP  = FETCH_PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jmpR,
  input  logic [ADDR_W-1:0]  jmpTarget,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemRdy,
  input  logic [INSTR_W-1:0] imemData,
  output logic               ifidValid,
  output logic [INSTR_W-1:0] ifidInstr,
  output logic [ADDR_W-1:0]  ifidPc,
  output fetch_state_t       dbg_state
);

  fetch_state_t        state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n, pc_inc, target;
  logic                req_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                ifid_load_mem, ifid_load_skid, ifid_clear;
  logic                skid_load, skid_unload, skid_clear;
  logic [INSTR_W-1:0]  skid_instr;
  logic [ADDR_W-1:0]   skid_pc;
  logic                skid_valid;
  logic                unused_target_bits;

  assign pc_inc             = pc + ADDR_W'(PC_STEP);  // wraps naturally
  assign target             = {jmpTarget[ADDR_W-1:2], 2'b00};
  assign unused_target_bits = ^jmpTarget[1:0];
  assign dbg_state          = state;

  // In S_REQ pc equals imemAddr; in S_DROP pc already holds the redirect
  // target while imemAddr still points at the request being discarded.
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    req_n          = imemReq;
    addr_n         = imemAddr;
    ifid_load_mem  = 1'b0;
    ifid_load_skid = 1'b0;
    ifid_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_unload    = 1'b0;
    skid_clear     = 1'b0;
    case (state)
      S_START: begin
        state_n = S_REQ;
        req_n   = 1'b1;
        addr_n  = pc;
      end
      S_REQ: begin
        if (jmpR) begin
          pc_n       = target;
          ifid_clear = 1'b1;
          skid_clear = 1'b1;
          if (imemRdy) addr_n = target;  // return dropped, reissue at target
          else         state_n = S_DROP; // old request must finish first
        end else if (imemRdy) begin
          pc_n = pc_inc;
          if (!stall) begin
            ifid_load_mem = 1'b1;
            addr_n        = pc_inc;
          end else begin
            skid_load = 1'b1;
            req_n     = 1'b0;
            state_n   = S_BUF;
          end
        end else if (!stall) begin
          ifid_clear = 1'b1;
        end
      end
      S_BUF: begin
        if (jmpR) begin
          pc_n       = target;
          ifid_clear = 1'b1;
          skid_clear = 1'b1;
          state_n    = S_REQ;
          req_n      = 1'b1;
          addr_n     = target;
        end else if (!stall) begin
          ifid_load_skid = 1'b1;
          skid_unload    = 1'b1;
          state_n        = S_REQ;
          req_n          = 1'b1;
          addr_n         = pc;
        end
      end
      S_DROP: begin
        if (jmpR) pc_n = target;
        if (imemRdy) begin
          state_n = S_REQ;
          addr_n  = jmpR ? target : pc;
        end
      end
      default: state_n = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_START;
      pc       <= ADDR_W'(RESET_PC);
      imemReq  <= 1'b0;
      imemAddr <= ADDR_W'(RESET_PC);
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      imemReq  <= req_n;
      imemAddr <= addr_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifidValid <= 1'b0;
      ifidInstr <= '0;
      ifidPc    <= '0;
    end else if (ifid_clear) begin
      ifidValid <= 1'b0;
    end else if (ifid_load_mem) begin
      ifidValid <= 1'b1;
      ifidInstr <= imemData;
      ifidPc    <= imemAddr;
    end else if (ifid_load_skid) begin
      ifidValid <= skid_valid;
      ifidInstr <= skid_instr;
      ifidPc    <= skid_pc;
    end
  end

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .in_instr (imemData),
    .in_pc    (imemAddr),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .valid    (skid_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         jmp_r;
  logic [31:0]  jmp_target;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_rdy;
  logic [31:0]  imem_data;
  logic         ifid_valid;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;
  fetch_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];  // {pc, instr}

  // bench model for the random section
  logic        m_buf, exp_valid, ld, s, r;
  logic [31:0] exp_addr, d, a;

  fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jmpR      (jmp_r),
    .jmpTarget (jmp_target),
    .imemReq   (imem_req),
    .imemAddr  (imem_addr),
    .imemRdy   (imem_rdy),
    .imemData  (imem_data),
    .ifidValid (ifid_valid),
    .ifidInstr (ifid_instr),
    .ifidPc    (ifid_pc),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_valid"}, 32'(ifid_valid), 32'd1);
      check_val({tag, "_pc"}, ifid_pc, e[63:32]);
      check_val({tag, "_instr"}, ifid_instr, e[31:0]);
    end
  endtask

  // drive one cycle of inputs, return 1 time unit after the rising edge
  task automatic step(input logic st, input logic rd, input logic j,
                      input logic [31:0] t, input logic [31:0] dat);
    stall = st; imem_rdy = rd; jmp_r = j; jmp_target = t; imem_data = dat;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] mem(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  initial begin
    rst = 1'b0; stall = 1'b0; jmp_r = 1'b0; jmp_target = '0;
    imem_rdy = 1'b0; imem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", 32'(imem_req), 32'd0);
    check_val("rst_addr", imem_addr, 32'd0);
    check_val("rst_valid", 32'(ifid_valid), 32'd0);
    check_val("rst_instr", ifid_instr, 32'd0);
    check_val("rst_pc", ifid_pc, 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(S_START));
    rst = 1'b1;

    // start-up and back-to-back fetch
    step(0, 0, 0, 0, 0);
    check_val("start_state", 32'(dbg_state), 32'(S_REQ));
    check_val("start_req", 32'(imem_req), 32'd1);
    check_val("start_addr", imem_addr, 32'd0);
    for (int i = 0; i < 2; i++) begin
      a = 32'(i * 4);
      exp_q.push_back({a, mem(a)});
      step(0, 1, 0, 0, mem(a));
      check_val("seq_addr", imem_addr, a + 4);
      check_pop("seq");
    end

    // stalled return goes to the skid buffer
    exp_q.push_back({32'h8, 32'hAAAA0001});
    step(1, 1, 0, 0, 32'hAAAA0001);
    for (int i = 0; i < 3; i++) begin
      check_val("buf_state", 32'(dbg_state), 32'(S_BUF));
      check_val("buf_req", 32'(imem_req), 32'd0);
      check_val("buf_hold_pc", ifid_pc, 32'h4);
      check_val("buf_hold_instr", ifid_instr, mem(32'h4));
      if (i < 2) step(1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0);
    check_pop("unbuf");
    check_val("unbuf_req", 32'(imem_req), 32'd1);
    check_val("unbuf_addr", imem_addr, 32'hC);
    for (a = 32'hC; a < 32'h20; a += 4) begin
      exp_q.push_back({a, mem(a)});
      step(0, 1, 0, 0, mem(a));
      check_val("seq2_addr", imem_addr, a + 4);
      check_pop("seq2");
    end

    // redirect while the request at 0x20 is still pending
    step(0, 0, 1, 32'h100, 0);
    check_val("drop_state", 32'(dbg_state), 32'(S_DROP));
    check_val("drop_addr", imem_addr, 32'h20);
    check_val("drop_req", 32'(imem_req), 32'd1);
    check_val("drop_valid", 32'(ifid_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    check_val("drop_addr2", imem_addr, 32'h20);
    step(0, 1, 0, 0, 32'hDEADBEEF);
    check_val("drop_done_valid", 32'(ifid_valid), 32'd0);
    check_val("drop_done_addr", imem_addr, 32'h100);
    check_val("drop_done_state", 32'(dbg_state), 32'(S_REQ));

    // redirect with the return in the same cycle, unaligned target
    step(0, 1, 1, 32'h203, mem(32'h100));
    check_val("jrdy_valid", 32'(ifid_valid), 32'd0);
    check_val("jrdy_addr", imem_addr, 32'h200);
    exp_q.push_back({32'h200, mem(32'h200)});
    step(0, 1, 0, 0, mem(32'h200));
    check_val("jrdy_next_addr", imem_addr, 32'h204);
    check_pop("jrdy_fetch");

    // newer redirect while already dropping replaces the target
    step(0, 0, 1, 32'h300, 0);
    step(0, 0, 1, 32'h400, 0);
    check_val("retarget_state", 32'(dbg_state), 32'(S_DROP));
    check_val("retarget_addr", imem_addr, 32'h204);
    step(0, 1, 0, 0, 32'h1234);
    check_val("retarget_next", imem_addr, 32'h400);

    // redirect overrides stall
    step(1, 1, 1, 32'h500, mem(32'h400));
    check_val("jstall_valid", 32'(ifid_valid), 32'd0);
    check_val("jstall_addr", imem_addr, 32'h500);

    // redirect in S_BUF squashes the parked word
    step(1, 1, 0, 0, mem(32'h500));
    check_val("jbuf_pre", 32'(dbg_state), 32'(S_BUF));
    step(1, 0, 1, 32'h600, 0);
    check_val("jbuf_state", 32'(dbg_state), 32'(S_REQ));
    check_val("jbuf_addr", imem_addr, 32'h600);
    check_val("jbuf_req", 32'(imem_req), 32'd1);
    check_val("jbuf_valid", 32'(ifid_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    check_val("jbuf_bubble", 32'(ifid_valid), 32'd0);

    // PC wrap
    step(0, 1, 1, 32'hFFFF_FFFC, mem(32'h600));
    check_val("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    exp_q.push_back({32'hFFFF_FFFC, mem(32'hFFFF_FFFC)});
    step(0, 1, 0, 0, mem(32'hFFFF_FFFC));
    check_pop("wrap");
    check_val("wrap_addr1", imem_addr, 32'h0);

    // random stall / memory wait states, no redirects
    m_buf = 1'b0; exp_addr = 32'h0; exp_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) != 0);
      d = $urandom;
      ld = 1'b0;
      if (!m_buf) begin
        if (r) begin
          exp_q.push_back({exp_addr, d});
          exp_addr += 4;
          if (s) m_buf = 1'b1;
          else begin ld = 1'b1; exp_valid = 1'b1; end
        end else if (!s) begin
          exp_valid = 1'b0;
        end
      end else if (!s) begin
        m_buf = 1'b0; ld = 1'b1; exp_valid = 1'b1;
      end
      step(s, r, 0, 0, d);
      check_val("rnd_valid", 32'(ifid_valid), 32'(exp_valid));
      check_val("rnd_req", 32'(imem_req), 32'(!m_buf));
      if (!m_buf) check_val("rnd_addr", imem_addr, exp_addr);
      if (ld) check_pop("rnd");
    end

    // asynchronous reset mid-request
    step(0, 0, 0, 0, 0);
    exp_q.delete();
    check_val("arst_pre_state", 32'(dbg_state), 32'(S_REQ));
    #2 rst = 1'b0;
    #1;
    check_val("arst_req", 32'(imem_req), 32'd0);
    check_val("arst_addr", imem_addr, 32'd0);
    check_val("arst_valid", 32'(ifid_valid), 32'd0);
    check_val("arst_instr", ifid_instr, 32'd0);
    check_val("arst_pc", ifid_pc, 32'd0);
    check_val("arst_state", 32'(dbg_state), 32'(S_START));
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    check_val("rel_req", 32'(imem_req), 32'd1);
    check_val("rel_addr", imem_addr, 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
